// File: rtl/envelope_vca_if.sv
// Sample-path bus between the oscillator source, the VCA and the mixer.
//
// Handshake: a sample transfers on a rising Clock edge where SampleValid and
// SampleReady are both high. The source must hold Sample steady while
// SampleValid is high and SampleReady is low. SampleReady depends only on
// the VCA state, never combinationally on SampleValid. OutValid is a
// one-cycle strobe with no back-pressure. Out holds its value between
// strobes.
interface envelope_vca_if #(
  parameter int WAVE_DEPTH   = 8,
  parameter int SAMPLE_DEPTH = 8
);
  logic signed [SAMPLE_DEPTH-1:0] Sample;
  logic                           SampleValid;
  logic                           SampleReady;
  logic        [WAVE_DEPTH-1:0]   Envelope;
  logic                           Running;
  logic signed [SAMPLE_DEPTH-1:0] Out;
  logic                           OutValid;
  logic                           Busy;

  modport master (
    output Sample, SampleValid, Envelope, Running,
    input  SampleReady, Out, OutValid, Busy
  );

  modport slave (
    input  Sample, SampleValid, Envelope, Running,
    output SampleReady, Out, OutValid, Busy
  );
endinterface

// File: rtl/envelope_vca.sv
// Envelope-controlled amplifier. Each accepted sample is multiplied by the
// envelope with a serial shift-add multiplier that consumes one envelope bit
// per clock. The product is scaled back down by 2^WAVE_DEPTH. A full-scale
// envelope passes the sample through exactly. A stopped ADSR or a zero
// envelope gives silence.
module envelope_vca #(
  parameter int WAVE_DEPTH   = 8,
  parameter int SAMPLE_DEPTH = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  envelope_vca_if.slave        bus,
  output logic [1:0]           State
);

  localparam int ACC_W = SAMPLE_DEPTH + WAVE_DEPTH;
  localparam int CNT_W = (WAVE_DEPTH > 1) ? $clog2(WAVE_DEPTH) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(WAVE_DEPTH - 1);
  localparam logic [WAVE_DEPTH-1:0] WAVE_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [ACC_W-1:0]        mcand;
  logic [WAVE_DEPTH-1:0]   env_sr;
  logic [ACC_W-1:0]        acc;
  logic [ACC_W-1:0]        acc_sum;
  logic [CNT_W-1:0]        cnt;
  logic                    gate;
  logic                    unity;
  logic [SAMPLE_DEPTH-1:0] sample_q;
  logic [SAMPLE_DEPTH-1:0] out_q;
  logic                    out_valid_q;
  logic                    ready;
  logic                    busy;
  logic                    accept;

  assign accept = (state == IDLE) && bus.SampleValid;

  // Partial product for the current envelope bit. The last one is folded in
  // combinationally so the result can be registered on the edge entering DONE.
  assign acc_sum = acc + (env_sr[0] ? mcand : '0);

  // State register.
  always_ff @(posedge Clock) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.SampleValid) state_next = MUL;
      end
      MUL: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, shift-add iteration and result register.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      mcand       <= '0;
      env_sr      <= '0;
      acc         <= '0;
      cnt         <= '0;
      gate        <= 1'b0;
      unity       <= 1'b0;
      sample_q    <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (accept) begin
        mcand    <= {{WAVE_DEPTH{bus.Sample[SAMPLE_DEPTH-1]}}, bus.Sample};
        env_sr   <= bus.Envelope;
        gate     <= bus.Running && (bus.Envelope != '0);
        unity    <= (bus.Envelope == WAVE_MAX);
        sample_q <= bus.Sample;
        acc      <= '0;
        cnt      <= '0;
      end else if (state == MUL) begin
        acc    <= acc_sum;
        mcand  <= mcand << 1;
        env_sr <= env_sr >> 1;
        cnt    <= cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          out_valid_q <= 1'b1;
          // The upper SAMPLE_DEPTH bits form the floor of product / 2^WAVE_DEPTH.
          // They always fit because the envelope is below 2^WAVE_DEPTH.
          if (!gate)      out_q <= '0;
          else if (unity) out_q <= sample_q;
          else            out_q <= acc_sum[ACC_W-1:WAVE_DEPTH];
        end
      end
    end
  end

  assign bus.SampleReady = ready;
  assign bus.Busy        = busy;
  assign bus.Out         = out_q;
  assign bus.OutValid    = out_valid_q;
  assign State           = state;

endmodule

// File: doc/envelope_vca.md
Name: envelope_vca

Overview:
- Voltage-controlled amplifier stage sitting directly downstream of the ADSR envelope generator.
- Scales each oscillator sample by the current envelope value and emits the amplitude-shaped sample to the mixer.
- Uses a serial shift-add multiplier, one envelope bit per clock, to keep area small.
- Handshakes with the sample source using valid/ready and flags each result with a one-cycle valid pulse.

Parameters:
- WAVE_DEPTH, 8, envelope width in bits (unsigned; WAVE_MAX = 2^WAVE_DEPTH-1).
- SAMPLE_DEPTH, 8, sample width in bits (signed two's complement, input and output).

Ports:
- Clock  input  1  system clock; all logic on posedge.
- Reset  input  1  synchronous, active-low reset.
- Sample  input  SAMPLE_DEPTH  signed oscillator sample.
- SampleValid  input  1  Sample is presented this cycle.
- SampleReady  output  1  block can accept a sample this cycle.
- Envelope  input  WAVE_DEPTH  unsigned envelope from the ADSR block.
- Running  input  1  ADSR Running flag; low forces silent output.
- Out  output  SAMPLE_DEPTH  signed scaled sample; holds until the next result.
- OutValid  output  1  one-cycle pulse when Out updates.
- Busy  output  1  high while a multiply is in progress (MUL or DONE).

Behaviour:
- Reset (Reset==0 at posedge):
  - state=IDLE; Out=0; OutValid=0; Busy=0; SampleReady=1.
  - Accumulator and bit counter cleared.
  - Reset has priority over every other event.
- States: IDLE, MUL, DONE.
- IDLE:
  - SampleReady=1, Busy=0.
  - On SampleValid==1, accept:
    - latch Sample into a multiplicand register, sign-extended to SAMPLE_DEPTH+WAVE_DEPTH.
    - latch Envelope into an envelope shift register.
    - latch the gating flag gate = Running && (Envelope != 0).
    - latch unity = (Envelope == WAVE_MAX).
    - clear the accumulator; counter=0; go to MUL.
- MUL (exactly WAVE_DEPTH cycles):
  - SampleReady=0, Busy=1.
  - Each cycle: if the envelope shift register LSB is 1, add multiplicand to the accumulator.
  - Then shift the multiplicand left 1, shift the envelope register right 1, and increment the counter.
  - Leave MUL after the counter reaches WAVE_DEPTH-1.
- DONE (1 cycle):
  - Out is registered at the DONE posedge; OutValid=1 for this cycle only; SampleReady=0.
  - Out selection:
    - if gate==0: Out=0.
    - else if unity: Out=latched Sample (exact pass-through).
    - else: Out = accumulator arithmetically shifted right by WAVE_DEPTH (floor), truncated to SAMPLE_DEPTH.
  - Truncation never overflows because Envelope < 2^WAVE_DEPTH.
  - Next state IDLE.
- Timing:
  - Accept at posedge t gives OutValid high in cycle t+WAVE_DEPTH+1.
  - Latency is fixed and does not depend on Envelope, Running or Sample.
  - With SampleValid held high, accepts occur every WAVE_DEPTH+2 cycles.
  - SampleReady rises the cycle after DONE.
- Input timing:
  - Envelope and Running are sampled only at accept; changes during MUL/DONE do not affect the in-flight result.
  - SampleValid during MUL/DONE is ignored; the source must hold Sample until it sees SampleReady.
- Reset mid-operation: the in-flight result is discarded, no OutValid pulse is issued, and Out=0.
- Out holds its value between results; OutValid never asserts two consecutive cycles.

Test Plan:
- Reset held low 3 cycles with SampleValid=1 -> Out=0, OutValid=0, SampleReady=1 throughout; after release the first accept yields OutValid exactly at t+9 (defaults).
- Sample=100, Envelope=128, Running=1 -> Out=50; Sample=-100, Envelope=128 -> Out=-50; Sample=-1, Envelope=1 -> Out=-1 (floor).
- Envelope=255, Sample=127 -> Out=127; Envelope=255, Sample=-128 -> Out=-128 (unity pass-through); Envelope=0, Sample=77 -> Out=0.
- Running=0, Envelope=200, Sample=90 -> Out=0 with the same latency; Envelope changed to 0 during MUL after accepting with Envelope=64, Sample=64 -> Out=16.
- SampleValid held high with Samples 10, 20, 30 and Envelope=128 -> accepts spaced 10 cycles apart, Outs 5, 10, 15, single-cycle OutValid each; SampleReady low while Busy.
- Reset asserted in the 4th MUL cycle -> no OutValid, Out=0, state IDLE on the next cycle; a new Sample=40, Envelope=64 then gives Out=10.
